// File: rtl/acc_result_drain.sv
// acc_result_drain: requantizes MAC lane results and serializes them,
// lowest lane first, through a FWFT FIFO onto a valid/ready stream.
module acc_result_drain #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  input  logic                    relu_en,
  input  logic [3:0]              shift,
  output logic signed [W-1:0]     out_data,
  output logic [1:0]              out_lane,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    drop_err,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((1 << (W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef struct packed {
    logic [1:0]         lane;
    logic signed [W-1:0] data;
  } ent_t;

  function automatic logic signed [W-1:0] requant(
    input logic signed [ACC_W-1:0] a,
    input logic [3:0]              sh,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] x;
    x = a >>> sh;
    if (relu && x[ACC_W-1]) x = '0;
    if (x > SAT_HI) x = SAT_HI;
    else if (x < SAT_LO) x = SAT_LO;
    return x[W-1:0];
  endfunction

  logic signed [ACC_W-1:0] acc [N_MACS];
  logic signed [W-1:0]     qv [N_MACS];
  logic signed [W-1:0]     pdata [N_MACS];

  logic [N_MACS-1:0] pend;
  logic [N_MACS-1:0] pend_n;
  logic [N_MACS-1:0] take;
  logic [N_MACS-1:0] push_oh;
  logic [1:0]        sel;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;

  ent_t           mem [DEPTH];
  ent_t           head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  assign acc[0] = acc_in_0;
  assign acc[1] = acc_in_1;
  assign acc[2] = acc_in_2;
  assign acc[3] = acc_in_3;

  always_comb begin
    for (int i = 0; i < N_MACS; i++) begin
      qv[i] = requant(acc[i], shift, relu_en);
    end
  end

  assign full = (count == CW'(DEPTH));
  assign push = (|pend) && !full;
  assign pop  = out_valid && out_ready;

  always_comb begin
    sel = '0;
    for (int i = N_MACS-1; i >= 0; i--) begin
      if (pend[i]) sel = 2'(i);
    end
  end

  always_comb begin
    push_oh = '0;
    if (push) push_oh[sel] = 1'b1;
  end

  // A lane leaving this cycle may accept a new strobe; otherwise it drops.
  always_comb begin
    take = '0;
    drop = 1'b0;
    for (int i = 0; i < N_MACS; i++) begin
      if (valid_in[i]) begin
        if (!pend[i] || push_oh[i]) take[i] = 1'b1;
        else drop = 1'b1;
      end
    end
    pend_n = (pend & ~push_oh) | take;
    if (clear) begin
      pend_n = '0;
      take   = '0;
      drop   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < N_MACS; i++) pdata[i] <= '0;
    end else begin
      pend <= pend_n;
      if (drop) drop_err <= 1'b1;
      for (int i = 0; i < N_MACS; i++) begin
        if (take[i]) pdata[i] <= qv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= '{lane: sel, data: pdata[sel]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head.data : '0;
  assign out_lane   = out_valid ? head.lane : '0;
  assign fifo_count = count;
  assign busy       = (|pend) || out_valid;

endmodule
